// File: rtl/sprite_ram_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_ram_ctrl
//
// Controller that owns both ports of one sprite bitmap RAM. The RAM has a
// synchronous write port and a registered read port (data appears one cycle
// after the read address is presented, read-before-write on a collision).
//
// Write port: shared between host bus writes and a fill engine that paints
// every pixel of the bitmap with one colour. A small IDLE/FILL state machine
// drives registered RAM write signals.
//
// Read port: the video sampler has absolute priority while vid_en is high.
// Otherwise host reads are accepted and their data is returned one cycle
// later with a single-cycle bus_rvalid pulse.
//
// Parameters
//   ADDR_WIDTH   RAM address bits; bitmap holds 2**ADDR_WIDTH pixels
//   DATA_WIDTH   colour index bits per pixel
//
// Ports
//   clk           in   system clock
//   reset_n       in   asynchronous, active-low reset
//   bus_wr        in   host write request, held until accepted
//   bus_waddr     in   host write address
//   bus_wdata     in   host write data
//   bus_wr_ready  out  write accepted when bus_wr & bus_wr_ready
//   bus_rd        in   host read request, held until accepted
//   bus_raddr     in   host read address
//   bus_rd_ready  out  read accepted when bus_rd & bus_rd_ready
//   bus_rvalid    out  one-cycle pulse, bus_rdata valid
//   bus_rdata     out  readback data (holds last value between reads)
//   fill_start    in   pulse: fill whole bitmap with fill_value
//   fill_value    in   fill colour, captured together with fill_start
//   fill_abort    in   stop a running fill / cancel a pending one
//   fill_busy     out  fill engine running
//   fill_done     out  one-cycle pulse on fill completion (not on abort)
//   vid_en        in   video sampler owns the read port
//   vid_addr      in   video read address
//   ram_we        out  RAM write enable
//   ram_addr_w    out  RAM write address
//   ram_din       out  RAM write data
//   ram_addr_r    out  RAM read address (combinational mux)
//   ram_dout      in   RAM read data, valid one cycle after ram_addr_r
// -----------------------------------------------------------------------------
module sprite_ram_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  bus_wr,
    input  logic [ADDR_WIDTH-1:0] bus_waddr,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    output logic                  bus_wr_ready,

    input  logic                  bus_rd,
    input  logic [ADDR_WIDTH-1:0] bus_raddr,
    output logic                  bus_rd_ready,
    output logic                  bus_rvalid,
    output logic [DATA_WIDTH-1:0] bus_rdata,

    input  logic                  fill_start,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic                  fill_abort,
    output logic                  fill_busy,
    output logic                  fill_done,

    input  logic                  vid_en,
    input  logic [ADDR_WIDTH-1:0] vid_addr,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } wr_state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    wr_state_t             state;
    logic                  fill_pend;   // fill requested, waiting for a free write slot
    logic [DATA_WIDTH-1:0] fill_val;    // colour captured at fill_start
    logic [ADDR_WIDTH-1:0] fill_cnt;    // next address the fill engine writes
    logic [DATA_WIDTH-1:0] rdata_q;     // last returned readback value

    // -------------------------------------------------------------------------
    // Write side
    // -------------------------------------------------------------------------
    // Host writes are only taken while the fill engine is idle; a write held
    // during a fill simply waits for the first IDLE cycle.
    assign bus_wr_ready = (state == IDLE);

    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples the values from before the clock edge, independent of
    // statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            fill_pend  <= 1'b0;
            fill_val   <= '0;
            fill_cnt   <= '0;
            fill_busy  <= 1'b0;
            fill_done  <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr_w <= '0;
            ram_din    <= '0;
        end else begin
            // NOTE: single-cycle strobes default low at the top of the block, so
            // each branch only states when they pulse.
            ram_we    <= 1'b0;
            fill_done <= 1'b0;

            case (state)
                IDLE: begin
                    // Host write always wins the write port in IDLE.
                    if (bus_wr) begin
                        ram_we     <= 1'b1;
                        ram_addr_w <= bus_waddr;
                        ram_din    <= bus_wdata;
                    end

                    if (fill_abort) begin
                        // Cancels a fill that has been requested but not launched.
                        fill_pend <= 1'b0;
                    end else if (fill_pend && !bus_wr) begin
                        // Launch: the first fill write is issued in the next cycle.
                        state     <= FILL;
                        fill_cnt  <= '0;
                        fill_pend <= 1'b0;
                        fill_busy <= 1'b1;
                    end else if (fill_start) begin
                        fill_pend <= 1'b1;
                        fill_val  <= fill_value;
                    end
                end

                FILL: begin
                    // fill_start is deliberately ignored here: a new request
                    // during a fill is dropped, not queued.
                    if (fill_abort) begin
                        state     <= IDLE;
                        fill_busy <= 1'b0;
                    end else begin
                        ram_we     <= 1'b1;
                        ram_addr_w <= fill_cnt;
                        ram_din    <= fill_val;
                        fill_cnt   <= fill_cnt + 1'b1;
                        // Completion is detected on the all-ones address rather
                        // than on the counter wrapping, so the last write and the
                        // done pulse leave the block on the same edge.
                        if (fill_cnt == LAST_ADDR) begin
                            state     <= IDLE;
                            fill_busy <= 1'b0;
                            fill_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    fill_busy <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Read side (independent of the write state machine)
    // -------------------------------------------------------------------------
    assign bus_rd_ready = !vid_en;
    assign ram_addr_r   = vid_en ? vid_addr : bus_raddr;

    // bus_rvalid marks the cycle in which the RAM presents the data for the
    // read accepted on the previous edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_rvalid <= 1'b0;
            rdata_q    <= '0;
        end else begin
            bus_rvalid <= bus_rd && !vid_en;
            if (bus_rvalid) begin
                rdata_q <= ram_dout;
            end
        end
    end

    // The RAM output register already holds the requested word in the rvalid
    // cycle; it is forwarded then and captured locally so bus_rdata stays
    // stable afterwards while the video sampler keeps moving the RAM output.
    assign bus_rdata = bus_rvalid ? ram_dout : rdata_q;

endmodule

// File: tb/tb_sprite_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_ram_ctrl
//
// Directed bench for sprite_ram_ctrl with a 16-pixel bitmap (ADDR_WIDTH=4).
// A behavioural RAM (registered read, read-before-write) sits on the RAM ports.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_sprite_ram_ctrl;

    localparam int AW = 4;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          bus_wr;
    logic [AW-1:0] bus_waddr;
    logic [DW-1:0] bus_wdata;
    logic          bus_wr_ready;
    logic          bus_rd;
    logic [AW-1:0] bus_raddr;
    logic          bus_rd_ready;
    logic          bus_rvalid;
    logic [DW-1:0] bus_rdata;
    logic          fill_start;
    logic [DW-1:0] fill_value;
    logic          fill_abort;
    logic          fill_busy;
    logic          fill_done;
    logic          vid_en;
    logic [AW-1:0] vid_addr;
    logic          ram_we;
    logic [AW-1:0] ram_addr_w;
    logic [DW-1:0] ram_din;
    logic [AW-1:0] ram_addr_r;
    logic [DW-1:0] ram_dout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sprite_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus_wr       (bus_wr),
        .bus_waddr    (bus_waddr),
        .bus_wdata    (bus_wdata),
        .bus_wr_ready (bus_wr_ready),
        .bus_rd       (bus_rd),
        .bus_raddr    (bus_raddr),
        .bus_rd_ready (bus_rd_ready),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata),
        .fill_start   (fill_start),
        .fill_value   (fill_value),
        .fill_abort   (fill_abort),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .vid_en       (vid_en),
        .vid_addr     (vid_addr),
        .ram_we       (ram_we),
        .ram_addr_w   (ram_addr_w),
        .ram_din      (ram_din),
        .ram_addr_r   (ram_addr_r),
        .ram_dout     (ram_dout)
    );

    // Sprite RAM: synchronous write, registered read of the old contents.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr_w] <= ram_din;
        ram_dout <= mem[ram_addr_r];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host read: one accept cycle, data checked in the following cycle.
    task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
        bus_rd    = 1'b1;
        bus_raddr = addr;
        tick();
        bus_rd = 1'b0;
        checks++;
        if (bus_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s rvalid: got=%0b exp=1", name, bus_rvalid);
        end
        checks++;
        if (bus_rdata !== exp) begin
            errors++;
            $display("FAIL %s rdata[%0d]: got=%0d exp=%0d", name, addr, bus_rdata, exp);
        end
    endtask

    task automatic test_reset();
        tick();
        bus_wr = 1'b1; bus_waddr = 4'd9; bus_wdata = 2'd1;
        tick();
        bus_wr = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({ram_we, ram_addr_w, ram_din} !== '0) begin
            errors++;
            $display("FAIL reset ram_w: got we=%0b a=%0d d=%0d exp all 0", ram_we, ram_addr_w, ram_din);
        end
        checks++;
        if ({fill_busy, fill_done, bus_rvalid, bus_rdata} !== '0) begin
            errors++;
            $display("FAIL reset status: got busy=%0b done=%0b rv=%0b rd=%0d exp all 0",
                     fill_busy, fill_done, bus_rvalid, bus_rdata);
        end
        checks++;
        if (bus_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset wr_ready: got=%0b exp=1", bus_wr_ready);
        end
        @(negedge clk) reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        bus_wr = 1'b1; bus_waddr = 4'd5; bus_wdata = 2'd2;
        tick();
        bus_wr = 1'b0;
        checks++;
        if ({ram_we, ram_addr_w, ram_din} !== {1'b1, 4'd5, 2'd2}) begin
            errors++;
            $display("FAIL wr ram_w: got we=%0b a=%0d d=%0d exp we=1 a=5 d=2", ram_we, ram_addr_w, ram_din);
        end
        tick();
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL wr idle we: got=%0b exp=0", ram_we);
        end
        bus_rd = 1'b1; bus_raddr = 4'd5;
        #1;
        checks++;
        if (bus_rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd_ready: got=%0b exp=1", bus_rd_ready);
        end
        tick();
        bus_rd = 1'b0;
        checks++;
        if ({bus_rvalid, bus_rdata} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL rd addr5: got rv=%0b d=%0d exp rv=1 d=2", bus_rvalid, bus_rdata);
        end
        tick();
        checks++;
        if ({bus_rvalid, bus_rdata} !== {1'b0, 2'd2}) begin
            errors++;
            $display("FAIL rd after: got rv=%0b d=%0d exp rv=0 d=2 (held)", bus_rvalid, bus_rdata);
        end
    endtask

    task automatic test_fill();
        fill_value = 2'd3; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        checks++;
        if (fill_busy !== 1'b0) begin
            errors++;
            $display("FAIL fill pend busy: got=%0b exp=0", fill_busy);
        end
        tick();
        checks++;
        if ({fill_busy, ram_we} !== 2'b10) begin
            errors++;
            $display("FAIL fill launch: got busy=%0b we=%0b exp busy=1 we=0", fill_busy, ram_we);
        end
        bus_wr = 1'b1; bus_waddr = 4'd7; bus_wdata = 2'd1;
        #1;
        checks++;
        if (bus_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill wr_ready: got=%0b exp=0", bus_wr_ready);
        end
        tick();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({ram_we, ram_addr_w, ram_din} !== {1'b1, AW'(k), 2'd3}) begin
                errors++;
                $display("FAIL fill w%0d: got we=%0b a=%0d d=%0d exp we=1 a=%0d d=3",
                         k, ram_we, ram_addr_w, ram_din, k);
            end
            checks++;
            if (k < 15 && {fill_done, fill_busy, bus_wr_ready} !== 3'b010) begin
                errors++;
                $display("FAIL fill st%0d: got done=%0b busy=%0b rdy=%0b exp 0 1 0",
                         k, fill_done, fill_busy, bus_wr_ready);
            end else if (k == 15 && {fill_done, fill_busy, bus_wr_ready} !== 3'b101) begin
                errors++;
                $display("FAIL fill end: got done=%0b busy=%0b rdy=%0b exp 1 0 1",
                         fill_done, fill_busy, bus_wr_ready);
            end
            tick();
        end
        bus_wr = 1'b0;
        checks++;
        if ({ram_we, ram_addr_w, ram_din, fill_done} !== {1'b1, 4'd7, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL fill held wr: got we=%0b a=%0d d=%0d done=%0b exp 1 7 1 0",
                     ram_we, ram_addr_w, ram_din, fill_done);
        end
        tick();
        do_read(4'd7, 2'd1, "fill_rd7");
        do_read(4'd0, 2'd3, "fill_rd0");
        do_read(4'd15, 2'd3, "fill_rd15");
    endtask

    task automatic test_fill_and_write();
        fill_value = 2'd0; fill_start = 1'b1;
        bus_wr = 1'b1; bus_waddr = 4'd4; bus_wdata = 2'd2;
        tick();
        fill_start = 1'b0; bus_wr = 1'b0;
        checks++;
        if ({ram_we, ram_addr_w, ram_din, fill_busy} !== {1'b1, 4'd4, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL fw first: got we=%0b a=%0d d=%0d busy=%0b exp 1 4 2 0",
                     ram_we, ram_addr_w, ram_din, fill_busy);
        end
        tick();
        checks++;
        if ({fill_busy, ram_we} !== 2'b10) begin
            errors++;
            $display("FAIL fw launch: got busy=%0b we=%0b exp busy=1 we=0", fill_busy, ram_we);
        end
        tick();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({ram_we, ram_addr_w, ram_din} !== {1'b1, AW'(k), 2'd0}) begin
                errors++;
                $display("FAIL fw w%0d: got we=%0b a=%0d d=%0d exp we=1 a=%0d d=0",
                         k, ram_we, ram_addr_w, ram_din, k);
            end
            if (k == 0) begin
                bus_rd = 1'b1; bus_raddr = 4'd4;
            end else if (k == 1) begin
                bus_rd = 1'b0;
                checks++;
                if ({bus_rvalid, bus_rdata} !== {1'b1, 2'd2}) begin
                    errors++;
                    $display("FAIL fw rd during fill: got rv=%0b d=%0d exp rv=1 d=2", bus_rvalid, bus_rdata);
                end
            end else if (k == 15) begin
                checks++;
                if (fill_done !== 1'b1) begin
                    errors++;
                    $display("FAIL fw done: got=%0b exp=1", fill_done);
                end
            end
            tick();
        end
        do_read(4'd4, 2'd0, "fw_rd4");
    endtask

    task automatic test_abort();
        fill_value = 2'd1; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({ram_we, ram_addr_w, ram_din} !== {1'b1, AW'(k), 2'd1}) begin
                errors++;
                $display("FAIL ab w%0d: got we=%0b a=%0d d=%0d exp we=1 a=%0d d=1",
                         k, ram_we, ram_addr_w, ram_din, k);
            end
            if (k == 5) fill_abort = 1'b1;
            tick();
        end
        fill_abort = 1'b0;
        checks++;
        if ({ram_we, fill_busy, fill_done, bus_wr_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL ab stop: got we=%0b busy=%0b done=%0b rdy=%0b exp 0 0 0 1",
                     ram_we, fill_busy, fill_done, bus_wr_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({ram_we, fill_done} !== 2'b00) begin
                errors++;
                $display("FAIL ab quiet%0d: got we=%0b done=%0b exp 0 0", i, ram_we, fill_done);
            end
        end
        do_read(4'd5, 2'd1, "ab_rd5");
        do_read(4'd6, 2'd0, "ab_rd6");
        do_read(4'd15, 2'd0, "ab_rd15");
        // Abort while a fill is only pending: it must never launch.
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0; fill_abort = 1'b1;
        tick();
        fill_abort = 1'b0;
        tick();
        tick();
        checks++;
        if ({fill_busy, ram_we} !== 2'b00) begin
            errors++;
            $display("FAIL ab pend: got busy=%0b we=%0b exp 0 0", fill_busy, ram_we);
        end
    endtask

    task automatic test_video();
        bus_wr = 1'b1; bus_waddr = 4'd9; bus_wdata = 2'd2;
        tick();
        bus_wr = 1'b0;
        tick();
        vid_en = 1'b1; vid_addr = 4'd3; bus_rd = 1'b1; bus_raddr = 4'd9;
        #1;
        checks++;
        if ({ram_addr_r, bus_rd_ready} !== {4'd3, 1'b0}) begin
            errors++;
            $display("FAIL vid own: got addr_r=%0d rdy=%0b exp 3 0", ram_addr_r, bus_rd_ready);
        end
        tick();
        checks++;
        if (bus_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL vid rv1: got=%0b exp=0", bus_rvalid);
        end
        vid_addr = 4'd12;
        #1;
        checks++;
        if (ram_addr_r !== 4'd12) begin
            errors++;
            $display("FAIL vid track: got addr_r=%0d exp 12", ram_addr_r);
        end
        tick();
        checks++;
        if (bus_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL vid rv2: got=%0b exp=0", bus_rvalid);
        end
        vid_en = 1'b0;
        #1;
        checks++;
        if ({ram_addr_r, bus_rd_ready} !== {4'd9, 1'b1}) begin
            errors++;
            $display("FAIL vid release: got addr_r=%0d rdy=%0b exp 9 1", ram_addr_r, bus_rd_ready);
        end
        tick();
        bus_rd = 1'b0;
        checks++;
        if ({bus_rvalid, bus_rdata} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL vid rd: got rv=%0b d=%0d exp rv=1 d=2", bus_rvalid, bus_rdata);
        end
        tick();
        checks++;
        if (bus_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL vid once: got rv=%0b exp 0", bus_rvalid);
        end
    endtask

    task automatic test_same_addr();
        bus_wr = 1'b1; bus_waddr = 4'd9; bus_wdata = 2'd1;
        tick();
        bus_wr = 1'b0; bus_rd = 1'b1; bus_raddr = 4'd9;
        tick();
        bus_rd = 1'b0;
        checks++;
        if ({bus_rvalid, bus_rdata} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL rbw old: got rv=%0b d=%0d exp rv=1 d=2", bus_rvalid, bus_rdata);
        end
        do_read(4'd9, 2'd1, "rbw_new");
    endtask

    task automatic test_reset_mid_fill();
        int bad;
        bad = 0;
        fill_value = 2'd2; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (fill_busy !== 1'b1) begin
            errors++;
            $display("FAIL rmf busy: got=%0b exp=1", fill_busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({fill_busy, ram_we, fill_done} !== 3'b000) begin
            errors++;
            $display("FAIL rmf async: got busy=%0b we=%0b done=%0b exp 0 0 0", fill_busy, ram_we, fill_done);
        end
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fill_done || ram_we || fill_busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rmf resumed: got %0d active cycles exp 0", bad);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        bus_wr     = 1'b0;
        bus_waddr  = '0;
        bus_wdata  = '0;
        bus_rd     = 1'b0;
        bus_raddr  = '0;
        fill_start = 1'b0;
        fill_value = '0;
        fill_abort = 1'b0;
        vid_en     = 1'b0;
        vid_addr   = '0;
        #12 reset_n = 1'b1;

        test_reset();
        test_write_read();
        test_fill();
        test_fill_and_write();
        test_abort();
        test_video();
        test_same_addr();
        test_reset_mid_fill();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
